// File: rtl/trap_ctrl.sv
// Commit-stage trap/CSR sequencer: decides per committing instruction whether
// to retire it, run a CSR read-modify-write, take ecall/irq, or execute mret.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inst_valid,
  input  logic [63:0] i_inst_pc,
  input  logic        i_is_ecall,
  input  logic        i_is_mret,
  input  logic        i_is_csr,
  input  logic [1:0]  i_csr_op,
  input  logic [11:0] i_csr_addr,
  input  logic [63:0] i_csr_src,
  input  logic        i_irq_pending,
  input  logic [63:0] i_csr_rdata,
  output logic        o_inst_ready,
  output logic        o_flush,
  output logic [11:0] o_csr_id,
  output logic        o_csr_re,
  output logic        o_csr_we,
  output logic [63:0] o_csr_wdata,
  output logic        o_ecall,
  output logic        o_mret,
  output logic        o_tint,
  output logic [63:0] o_epc,
  output logic        o_redirect_valid,
  output logic [63:0] o_redirect_pc,
  output logic        o_rd_we,
  output logic [63:0] o_rd_wdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CSR_RD = 3'd1,
    CSR_WR = 3'd2,
    TRAP   = 3'd3,
    RET    = 3'd4,
    REDIR  = 3'd5
  } state_t;

  localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_target;  // mtvec or mepc, captured one cycle before redirect
  logic [63:0] r_old;     // CSR value before the read-modify-write
  logic        r_irq;     // current TRAP is an interrupt, not an ecall
  logic        r_ack;     // REDIR retires the instruction (ecall/mret, not irq)
  logic [63:0] w_new;
  logic        w_csr_we;

  always_comb begin
    unique case (i_csr_op)
      2'b10:   w_new = r_old | i_csr_src;
      2'b11:   w_new = r_old & ~i_csr_src;
      default: w_new = i_csr_src;  // 01 write, 00 treated as write
    endcase
  end

  // set/clear with a zero mask must not touch the CSR (side-effect free read)
  assign w_csr_we = !(i_csr_op[1] && (i_csr_src == 64'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_old    <= '0;
      r_irq    <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_inst_valid) begin
        r_irq <= i_irq_pending;
        r_ack <= !i_irq_pending;
      end
      if (r_state == TRAP || r_state == RET) r_target <= i_csr_rdata;
      if (r_state == CSR_RD)                 r_old    <= i_csr_rdata;
    end
  end

  always_comb begin
    w_next           = r_state;
    o_inst_ready     = 1'b0;
    o_flush          = 1'b0;
    o_csr_id         = '0;
    o_csr_re         = 1'b0;
    o_csr_we         = 1'b0;
    o_csr_wdata      = '0;
    o_ecall          = 1'b0;
    o_mret           = 1'b0;
    o_tint           = 1'b0;
    o_epc            = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_rd_we          = 1'b0;
    o_rd_wdata       = '0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (i_inst_valid) begin
            if (i_irq_pending)   w_next = TRAP;
            else if (i_is_ecall) w_next = TRAP;
            else if (i_is_mret)  w_next = RET;
            else if (i_is_csr)   w_next = CSR_RD;
            else                 o_inst_ready = 1'b1;
          end
        end
        CSR_RD: begin
          o_csr_id = i_csr_addr;
          o_csr_re = 1'b1;
          w_next   = CSR_WR;
        end
        CSR_WR: begin
          o_csr_id     = i_csr_addr;
          o_csr_we     = w_csr_we;
          o_csr_wdata  = w_csr_we ? w_new : 64'd0;
          o_rd_we      = 1'b1;
          o_rd_wdata   = r_old;
          o_inst_ready = 1'b1;
          w_next       = IDLE;
        end
        TRAP: begin
          o_epc = i_inst_pc;
          if (r_irq) begin
            o_tint  = 1'b1;
            o_flush = 1'b1;
          end else begin
            o_ecall     = 1'b1;
            o_csr_wdata = MCAUSE_ECALL_M;
          end
          w_next = REDIR;
        end
        RET: begin
          o_mret = 1'b1;
          w_next = REDIR;
        end
        REDIR: begin
          o_redirect_valid = 1'b1;
          o_redirect_pc    = r_target;
          o_inst_ready     = r_ack;
          w_next           = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed and random commit sequences compared cycle by
// cycle against an expected output trace built from the instruction class.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, is_ecall, is_mret, is_csr, irq_pending;
  logic [63:0] inst_pc, csr_src, csr_rdata;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic        inst_ready, flush, csr_re, csr_we, ecall, mret, tint, redirect_valid, rd_we;
  logic [11:0] csr_id;
  logic [63:0] csr_wdata, epc, redirect_pc, rd_wdata;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .i_inst_valid(inst_valid), .i_inst_pc(inst_pc), .i_is_ecall(is_ecall),
    .i_is_mret(is_mret), .i_is_csr(is_csr), .i_csr_op(csr_op),
    .i_csr_addr(csr_addr), .i_csr_src(csr_src), .i_irq_pending(irq_pending),
    .i_csr_rdata(csr_rdata),
    .o_inst_ready(inst_ready), .o_flush(flush), .o_csr_id(csr_id),
    .o_csr_re(csr_re), .o_csr_we(csr_we), .o_csr_wdata(csr_wdata),
    .o_ecall(ecall), .o_mret(mret), .o_tint(tint), .o_epc(epc),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_rd_we(rd_we), .o_rd_wdata(rd_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ir; logic fl; logic [11:0] id; logic re; logic we; logic [63:0] wd;
    logic ec; logic mr; logic ti; logic [63:0] epc; logic rv; logic [63:0] rpc;
    logic rwe; logic [63:0] rwd;
  } outs_t;

  typedef struct {
    bit irq; bit ecall; bit mret; bit csr; bit late_irq;
    logic [1:0] op; logic [11:0] addr; logic [63:0] pc, src, rdata;
  } inst_t;

  outs_t obs;
  assign obs = {inst_ready, flush, csr_id, csr_re, csr_we, csr_wdata, ecall, mret,
                tint, epc, redirect_valid, redirect_pc, rd_we, rd_wdata};

  outs_t       exp_q[$], got_q[$];
  inst_t       ins_q[$];
  logic [63:0] rd_q[$];
  bit          vld_q[$], irq_q[$];
  int          n_chk = 0, n_pass = 0;

  // Expected per-cycle trace for one committing instruction (plus optional idle gap).
  task automatic model(input inst_t t, input bit gap);
    outs_t e;
    logic [63:0] nv;
    int n;
    bit wr;
    n = (t.irq || t.ecall || t.mret || t.csr) ? 3 : 1;
    case (t.op)
      2'b10:   nv = t.rdata | t.src;
      2'b11:   nv = t.rdata & ~t.src;
      default: nv = t.src;
    endcase
    wr = (t.op == 2'b10 || t.op == 2'b11) ? (t.src != 0) : 1'b1;
    for (int k = 0; k < n; k++) begin
      e = '0;
      ins_q.push_back(t);
      vld_q.push_back(!(t.irq && k == 2));
      irq_q.push_back(k == 0 ? t.irq : (t.late_irq ? 1'b1 : bit'($urandom % 2)));
      rd_q.push_back(k == 1 ? t.rdata : {$urandom, $urandom});
      if (n == 1) e.ir = 1;
      else if (t.irq) begin
        if (k == 1) begin e.ti = 1; e.fl = 1; e.epc = t.pc; end
        if (k == 2) begin e.rv = 1; e.rpc = t.rdata; end
      end else if (t.ecall) begin
        if (k == 1) begin e.ec = 1; e.epc = t.pc; e.wd = 64'd11; end
        if (k == 2) begin e.rv = 1; e.rpc = t.rdata; e.ir = 1; end
      end else if (t.mret) begin
        if (k == 1) e.mr = 1;
        if (k == 2) begin e.rv = 1; e.rpc = t.rdata; e.ir = 1; end
      end else begin
        if (k == 1) begin e.id = t.addr; e.re = 1; end
        if (k == 2) begin
          e.id = t.addr; e.we = wr; e.wd = wr ? nv : 64'd0;
          e.rwe = 1; e.rwd = t.rdata; e.ir = 1;
        end
      end
      exp_q.push_back(e);
    end
    if (gap) begin
      ins_q.push_back(t); vld_q.push_back(0); irq_q.push_back(bit'($urandom % 2));
      rd_q.push_back({$urandom, $urandom}); exp_q.push_back('0);
    end
  endtask

  // Applies queued stimulus one cycle at a time, sampling on the falling edge.
  task automatic drive();
    inst_t t;
    while (vld_q.size() > 0) begin
      t = ins_q.pop_front();
      inst_valid = vld_q.pop_front(); irq_pending = irq_q.pop_front();
      csr_rdata = rd_q.pop_front();
      inst_pc = t.pc; is_ecall = t.ecall; is_mret = t.mret; is_csr = t.csr;
      csr_op = t.op; csr_addr = t.addr; csr_src = t.src;
      @(negedge clk); got_q.push_back(obs);
      @(posedge clk); #1;
    end
    inst_valid = 0; irq_pending = 0;
  endtask

  function automatic inst_t mk(bit irq, bit ec, bit mr, bit cs, logic [1:0] op,
                               logic [11:0] a, logic [63:0] pc, logic [63:0] s,
                               logic [63:0] rd);
    inst_t t;
    t.irq = irq; t.ecall = ec; t.mret = mr; t.csr = cs; t.late_irq = 0;
    t.op = op; t.addr = a; t.pc = pc; t.src = s; t.rdata = rd;
    return t;
  endfunction

  task automatic test_reset();
    rst = 1; inst_valid = 1; irq_pending = 1; is_ecall = 0; is_mret = 0; is_csr = 0;
    csr_op = 0; csr_addr = 0; csr_src = 0; inst_pc = 0; csr_rdata = '1;
    repeat (2) begin
      @(negedge clk); n_chk++;
      if (obs !== outs_t'(0)) $display("FAIL reset_outs got=%h exp=0", obs); else n_pass++;
      @(posedge clk); #1;
    end
    rst = 0; inst_valid = 0; irq_pending = 0;
    @(negedge clk); n_chk++;
    if (obs !== outs_t'(0)) $display("FAIL post_reset got=%h exp=0", obs); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_plain();
    model(mk(0, 0, 0, 0, 2'b01, 12'h300, 64'h1000, 64'h5, 64'h9), 0);
    model(mk(0, 0, 0, 0, 2'b10, 12'h341, 64'h1004, 64'h0, 64'h7), 1);
    drive();
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== exp_q[k]) $display("FAIL plain c%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_csr();
    model(mk(0, 0, 0, 1, 2'b10, 12'h300, 64'h2000, 64'h80, 64'h8), 0);
    model(mk(0, 0, 0, 1, 2'b10, 12'h300, 64'h2004, 64'h0, 64'h8), 0);
    model(mk(0, 0, 0, 1, 2'b11, 12'h304, 64'h2008, 64'hF0, 64'hFF), 0);
    model(mk(0, 0, 0, 1, 2'b00, 12'h305, 64'h200C, 64'h0, 64'h44), 1);
    drive();
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== exp_q[k]) $display("FAIL csr c%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_ecall();
    model(mk(0, 1, 0, 0, 2'b01, 12'h0, 64'h80000010, 64'h0, 64'h80000100), 1);
    drive();
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== exp_q[k]) $display("FAIL ecall c%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_irq_ecall();
    model(mk(1, 1, 0, 0, 2'b01, 12'h0, 64'h80000020, 64'h0, 64'h80000100), 1);
    drive();
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== exp_q[k]) $display("FAIL irq_ecall c%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_mret();
    model(mk(0, 0, 1, 0, 2'b01, 12'h0, 64'h3000, 64'h0, 64'h80000024), 0);
    drive();
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== exp_q[k]) $display("FAIL mret c%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_irq_mid();
    inst_t t;
    t = mk(0, 0, 0, 1, 2'b01, 12'h300, 64'h4000, 64'h1234, 64'h77);
    t.late_irq = 1;  // irq rises during CSR_RD/CSR_WR and must wait for IDLE
    model(t, 0);
    model(mk(1, 0, 0, 0, 2'b01, 12'h0, 64'h4004, 64'h0, 64'h80000100), 0);
    drive();
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== exp_q[k]) $display("FAIL irq_mid c%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    inst_valid = 1; is_csr = 1; is_ecall = 0; is_mret = 0; irq_pending = 0;
    csr_op = 2'b01; csr_addr = 12'h300; csr_src = 64'hABCD; csr_rdata = 64'h5;
    @(posedge clk); #1;           // now in CSR_RD
    rst = 1;
    @(negedge clk); n_chk++;
    if (obs !== outs_t'(0)) $display("FAIL rst_in_csr_rd got=%h exp=0", obs); else n_pass++;
    @(posedge clk); #1;
    rst = 0; inst_valid = 0;
    @(negedge clk); n_chk++;
    if (obs !== outs_t'(0)) $display("FAIL after_rst_idle got=%h exp=0", obs); else n_pass++;
    @(posedge clk); #1;
    inst_valid = 1; is_csr = 0;   // plain retires at once only if back in IDLE
    @(negedge clk); n_chk++;
    if ({inst_ready, csr_re, csr_we} !== 3'b100)
      $display("FAIL rst_then_plain got=%b exp=100", {inst_ready, csr_re, csr_we});
    else n_pass++;
    @(posedge clk); #1;
    inst_valid = 0;
  endtask

  task automatic test_random();
    inst_t t;
    int kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom % 5;
      t = mk(($urandom % 4) == 0, kind == 1, kind == 2, kind >= 3, 2'($urandom),
             12'($urandom), {$urandom, $urandom}, ($urandom % 3 == 0) ? 64'd0 : {$urandom, $urandom},
             {$urandom, $urandom});
      model(t, ($urandom % 3) == 0);
    end
    drive();
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (got_q[k] !== exp_q[k]) $display("FAIL random c%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_plain();
    test_csr();
    test_ecall();
    test_irq_ecall();
    test_mret();
    test_irq_mid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have clk input 1: clock; all state updates on the rising edge.
REQ-002 SHALL have rst input 1: reset, synchronous, active-high.
REQ-003 SHALL have inst_valid input 1: an instruction is waiting at commit; held stable until inst_ready or flush.
REQ-004 SHALL have inst_pc input 64, is_ecall input 1, is_mret input 1, is_csr input 1: commit instruction PC and class; at most one class bit set.
REQ-005 SHALL have csr_op input 2 (01 write, 10 set, 11 clear, 00 illegal -> treated as write), csr_addr input 12, csr_src input 64: CSR instruction operands.
REQ-006 SHALL have irq_pending input 1: timer interrupt already gated by MIE and MTIE.
REQ-007 SHALL have inst_ready output 1: commit accepted this cycle.
REQ-008 SHALL have flush output 1: commit instruction discarded this cycle (interrupt).
REQ-009 SHALL have the CSR-file side outputs csr_id 12, csr_re 1, csr_we 1, csr_wdata 64, ecall 1, mret 1, tint 1, epc 64, and input csr_rdata 64.
REQ-010 SHALL have redirect_valid output 1 and redirect_pc output 64: fetch redirect.
REQ-011 SHALL have rd_we output 1 and rd_wdata output 64: old CSR value to the register file.

Function
REQ-012 SHALL implement the states IDLE, CSR_RD, CSR_WR, TRAP, RET, and REDIR.
REQ-013 In IDLE with inst_valid, SHALL apply the priority irq_pending > is_ecall > is_mret > is_csr > plain.
- irq_pending -> TRAP (irq).
- is_ecall -> TRAP (ecall).
- is_mret -> RET.
- is_csr -> CSR_RD.
- plain -> inst_ready=1 in the same cycle, remain in IDLE.
REQ-014 SHALL act on irq_pending only in IDLE with inst_valid=1; irq_pending arriving mid-sequence SHALL wait for the next IDLE boundary.
REQ-015 TRAP (irq), one cycle:
- tint=1, epc=inst_pc.
- latch csr_rdata (mtvec) into the target register.
- flush=1, inst_ready=0.
- next state REDIR.
REQ-016 TRAP (ecall), one cycle:
- ecall=1, epc=inst_pc, csr_wdata=64'd11 (mcause).
- latch csr_rdata (mtvec).
- next state REDIR, with inst_ready=1 asserted in REDIR.
REQ-017 RET, one cycle: mret=1, latch csr_rdata (mepc); next state REDIR, with inst_ready=1 asserted in REDIR.
REQ-018 REDIR, one cycle: redirect_valid=1, redirect_pc = latched target; next state IDLE.
REQ-019 CSR_RD, one cycle: csr_id=csr_addr, csr_re=1; latch csr_rdata as old; next state CSR_WR.
REQ-020 CSR_WR, one cycle:
- csr_id=csr_addr.
- new value: write = src; set = old|src; clear = old&~src.
- csr_we=1 unless op is set/clear and csr_src==0.
- csr_wdata=new.
- rd_we=1, rd_wdata=old.
- inst_ready=1.
- next state IDLE.
REQ-021 SHALL hold at most one of ecall, mret, tint, csr_re, csr_we high in any cycle.
REQ-022 SHALL drive all outputs 0 whenever they are not asserted by the current state.
REQ-023 Latencies: plain 0 cycles; CSR 2 cycles; ecall, mret and irq 2 cycles to redirect.
REQ-024 SHALL ignore inst_valid outside IDLE.

Reset
REQ-025 While rst=1: state=IDLE, latched target and old value = 0, every output = 0.
REQ-026 rst asserted mid-sequence SHALL abort it; no CSR strobe, inst_ready, or redirect in the cycle after reset.

Verification
REQ-027 Plain instruction, inst_valid=1, no irq -> inst_ready=1 in the same cycle, no CSR strobes.
REQ-028 CSR set with csr_addr=0x300, csr_rdata=0x8, csr_src=0x80 ->
- cycle 1: csr_re=1.
- cycle 2: csr_we=1, csr_wdata=0x88, rd_wdata=0x8, inst_ready=1.
- CSR set with csr_src=0 -> csr_we=0 but rd_we=1.
REQ-029 ecall at pc 0x80000010, csr_rdata=0x80000100 ->
- cycle 1: ecall=1, epc=0x80000010, csr_wdata=11.
- cycle 2: redirect_pc=0x80000100, inst_ready=1.
REQ-030 irq_pending and is_ecall together at pc 0x80000020 ->
- tint=1, ecall=0, flush=1.
- redirect to mtvec.
- inst_ready never asserted for that instruction.
REQ-031 mret, csr_rdata=0x80000024 -> mret=1, then redirect_valid=1 with redirect_pc=0x80000024.
- irq_pending rising during CSR_WR -> trap taken only at the next IDLE with inst_valid.
REQ-032 rst pulsed in CSR_RD -> next cycle IDLE, all outputs 0, csr_we never asserted.
